// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets, decode window sizes and byte-mask helper for the GPIO bank
package gpio_pkg;
  localparam logic [5:0] GPIO_OFF_OUT      = 6'h00;
  localparam logic [5:0] GPIO_OFF_DIR      = 6'h04;
  localparam logic [5:0] GPIO_OFF_IN       = 6'h08;
  localparam logic [5:0] GPIO_OFF_SET      = 6'h0C;
  localparam logic [5:0] GPIO_OFF_CLR      = 6'h10;
  localparam logic [5:0] GPIO_OFF_TOG      = 6'h14;
  localparam logic [5:0] GPIO_OFF_IRQ_EN   = 6'h18;
  localparam logic [5:0] GPIO_OFF_IRQ_PEND = 6'h1C;
  localparam logic [5:0] GPIO_OFF_IRQ_POL  = 6'h20;
  localparam int GPIO_WIN_BYTES     = 32;
  localparam int GPIO_WIN_BYTES_POL = 64;
  function automatic logic [31:0] gpio_mask_bytes(input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
    return r;
  endfunction
endpackage

// File: rtl/gpio_input_sync.sv
// gpio_input_sync: pad synchroniser chain, history flop and per-pin edge pulse (pol 0 = rise, 1 = fall)
module gpio_input_sync #(
  parameter int NUM_PINS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_PINS-1:0] pin_i,
  input  logic [NUM_PINS-1:0] pol_i,
  output logic [NUM_PINS-1:0] sync_o,
  output logic [NUM_PINS-1:0] edge_o
);
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] sync_d [SYNC_STAGES];
  logic [NUM_PINS-1:0] prev_q, prev_d;
  always_comb begin
    sync_d[0] = pin_i;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '{default: '0};
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign sync_o = sync_q[SYNC_STAGES-1];
  assign edge_o = (sync_o & ~prev_q & ~pol_i) | (~sync_o & prev_q & pol_i);
endmodule

// File: rtl/gpio_bank_controller.sv
// gpio_bank_controller: memory-mapped GPIO bank with set/clr/tog aliases and edge interrupts
// Define GPIO_IRQ_POLARITY_EN to add the IRQ_POL register at offset 0x20 (64-byte window).
module gpio_bank_controller
  import gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h00000FC0,
  parameter int          NUM_PINS    = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         riscv_addr,
  input  logic [31:0]         riscv_wdata,
  input  logic [3:0]          riscv_wmask,
  input  logic                riscv_rstrb,
  output logic [31:0]         riscv_rdata,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);
`ifdef GPIO_IRQ_POLARITY_EN
  localparam int WIN_LSB = $clog2(GPIO_WIN_BYTES_POL);
`else
  localparam int WIN_LSB = $clog2(GPIO_WIN_BYTES);
`endif
  localparam logic [NUM_PINS-1:0] ZERO = '0;
  logic                hit, we;
  logic [5:0]          off;
  logic [31:0]         bm32, wd32, rval, rdata_q, rdata_d;
  logic [NUM_PINS-1:0] bm, wd, sync, edge_p, pol;
  logic [NUM_PINS-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d, pend_q, pend_d;
  gpio_input_sync #(.NUM_PINS(NUM_PINS), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .pin_i(gpio_in), .pol_i(pol), .sync_o(sync), .edge_o(edge_p)
  );
  assign hit  = riscv_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB];
  assign off  = 6'(riscv_addr[WIN_LSB-1:0]) & 6'h3C;
  assign we   = hit && |riscv_wmask;
  assign bm32 = gpio_mask_bytes(32'hFFFF_FFFF, riscv_wmask);
  assign wd32 = gpio_mask_bytes(riscv_wdata, riscv_wmask);
  assign bm   = bm32[NUM_PINS-1:0];
  assign wd   = wd32[NUM_PINS-1:0];
`ifdef GPIO_IRQ_POLARITY_EN
  logic [NUM_PINS-1:0] pol_q, pol_d;
  assign pol_d = (we && off == GPIO_OFF_IRQ_POL) ? (pol_q & ~bm) | wd : pol_q;
  assign pol   = pol_q;
  always_ff @(posedge clk) pol_q <= reset ? ZERO : pol_d;
`else
  assign pol = ZERO;
`endif
  always_comb begin
    out_d = !we                   ? out_q
          : off == GPIO_OFF_OUT   ? (out_q & ~bm) | wd
          : off == GPIO_OFF_SET   ? out_q | wd
          : off == GPIO_OFF_CLR   ? out_q & ~wd
          : off == GPIO_OFF_TOG   ? out_q ^ wd
          : out_q;
    dir_d = (we && off == GPIO_OFF_DIR) ? (dir_q & ~bm) | wd : dir_q;
    en_d  = (we && off == GPIO_OFF_IRQ_EN) ? (en_q & ~bm) | wd : en_q;
    // a fresh edge in the same cycle as a W1C keeps the bit set
    pend_d = (pend_q & ~((we && off == GPIO_OFF_IRQ_PEND) ? wd : ZERO)) | (edge_p & en_q);
    rval = off == GPIO_OFF_OUT      ? 32'(out_q)
         : off == GPIO_OFF_DIR      ? 32'(dir_q)
         : off == GPIO_OFF_IN       ? 32'(sync)
         : off == GPIO_OFF_IRQ_EN   ? 32'(en_q)
         : off == GPIO_OFF_IRQ_PEND ? 32'(pend_q)
`ifdef GPIO_IRQ_POLARITY_EN
         : off == GPIO_OFF_IRQ_POL  ? 32'(pol)
`endif
         : 32'h0;
    rdata_d = riscv_rstrb ? (hit ? rval : 32'h0) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      dir_q   <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end
  assign riscv_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign irq         = |(pend_q & en_q);
endmodule
